spi_slave_core: RTL

- Serial front end of the SPI slave. It deserialises MOSI frames into 10-bit words for the single-port RAM stage.
- It drives rx_data/rx_valid into the RAM and consumes the RAM's dout/tx_valid response (tx_data/tx_valid here).
- It shifts read data back out on MISO.
- SPI bit clock equals clk. All sampling and driving happens on posedge clk.

---
 rtl/spi_slave_core_pkg.sv | 21 ++
 rtl/spi_slave_core_if.sv | 20 ++
 rtl/spi_miso_serializer.sv | 46 ++++
 rtl/spi_slave_core.sv | 102 ++++++++++
 4 files changed

// File: rtl/spi_slave_core_pkg.sv
// Shared types for the SPI slave front end: FSM states, frame width, control codes.
package spi_slave_core_pkg;
   localparam int MEM_W    = 8;
   localparam int RX_WIDTH = MEM_W + 2;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } spi_state_e;

   // Upper two bits of every received word; decoded by the RAM stage.
   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } control_e;
endpackage

// File: rtl/spi_slave_core_if.sv
// SPI pins plus the rx/tx strobe pair towards the single-port RAM stage.
interface spi_slave_core_if #(parameter int MEM_WIDTH = 8);
   logic                 SS_n;
   logic                 MOSI;
   logic                 MISO;
   logic [MEM_WIDTH+1:0] rx_data;
   logic                 rx_valid;
   logic [MEM_WIDTH-1:0] tx_data;
   logic                 tx_valid;

   modport master (
      output SS_n, MOSI, tx_data, tx_valid,
      input  MISO, rx_data, rx_valid
   );

   modport slave (
      input  SS_n, MOSI, tx_data, tx_valid,
      output MISO, rx_data, rx_valid
   );
endinterface

// File: rtl/spi_miso_serializer.sv
// Loads one read word and shifts it out MSB first, one bit per clk; MISO is 0 when idle.
module spi_miso_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] data,
   output logic         miso,
   output logic         busy,
   output logic         done
);
   localparam int BW = $clog2(W);

   logic [W-1:0]  sreg;
   logic [BW-1:0] left;
   logic          active;

   assign busy = active;
   // done marks the edge that returns MISO to 0 after the last data bit.
   assign done = active && (left == '0);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         miso   <= 1'b0;
         sreg   <= '0;
         left   <= '0;
         active <= 1'b0;
      end else if (load) begin
         miso   <= data[W-1];
         sreg   <= {data[W-2:0], 1'b0};
         left   <= BW'(W - 1);
         active <= 1'b1;
      end else if (active) begin
         if (left != '0) begin
            miso <= sreg[W-1];
            sreg <= {sreg[W-2:0], 1'b0};
            left <= left - 1'b1;
         end else begin
            miso   <= 1'b0;
            active <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/spi_slave_core.sv
// SPI slave front end: command bit + 10-bit frame deserialised into an rx strobe,
// RAM read data returned on MISO after a read-data frame.
module spi_slave_core
   import spi_slave_core_pkg::*;
#(
   parameter int MEM_WIDTH = 8,
   parameter int CNT_W     = 4
) (
   input logic             clk,
   input logic             rst_n,
   spi_slave_core_if.slave bus
);
   localparam int RXW = MEM_WIDTH + 2;

   spi_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [RXW-2:0]   shift;
   logic [RXW-1:0]   rx_data_q;
   logic             rx_valid_q;
   logic             rd_addr_seen;
   logic             tx_pending;

   logic             ser_abort;
   logic             ser_load;
   logic             ser_busy;
   logic             ser_done;

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

   assign ser_abort = (state != IDLE) && bus.SS_n;
   // Only the first tx_valid of a pending read is taken; repeats while shifting are dropped.
   assign ser_load  = tx_pending && bus.tx_valid && !ser_busy;

   spi_miso_serializer #(.W(MEM_WIDTH)) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (ser_abort),
      .load  (ser_load),
      .data  (bus.tx_data),
      .miso  (bus.MISO),
      .busy  (ser_busy),
      .done  (ser_done)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         shift        <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rd_addr_seen <= 1'b0;
         tx_pending   <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (ser_done)
            tx_pending <= 1'b0;

         if (ser_abort) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            tx_pending <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (!bus.SS_n)
                     state <= CHK_CMD;
               end
               CHK_CMD: begin
                  if (!bus.MOSI)
                     state <= WRITE;
                  else if (rd_addr_seen)
                     state <= READ_DATA;
                  else
                     state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  // Counter parks at RXW so trailing bits of an overlong frame are ignored.
                  if (cnt < CNT_W'(RXW)) begin
                     shift <= {shift[RXW-3:0], bus.MOSI};
                     cnt   <= cnt + 1'b1;
                     if (cnt == CNT_W'(RXW - 1)) begin
                        rx_data_q  <= {shift, bus.MOSI};
                        rx_valid_q <= 1'b1;
                        if (state == READ_ADD)
                           rd_addr_seen <= 1'b1;
                        if (state == READ_DATA) begin
                           rd_addr_seen <= 1'b0;
                           tx_pending   <= 1'b1;
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
